// File: rtl/halloween_pkg.sv
// Shared opcode constants and sequencer state encoding for the Halloween effect sequencer.
package halloween_pkg;

  localparam logic [3:0] ON        = 4'h0;
  localparam logic [3:0] RESET     = 4'h1;
  localparam logic [3:0] NOOP      = 4'h2;
  localparam logic [3:0] FOG       = 4'h3;
  localparam logic [3:0] GREEN     = 4'h4;
  localparam logic [3:0] PURPLE    = 4'h5;
  localparam logic [3:0] ORANGE    = 4'h6;
  localparam logic [3:0] SCREAMING = 4'h8;
  localparam logic [3:0] CACKLING  = 4'h9;
  localparam logic [3:0] BOO       = 4'hA;
  localparam logic [3:0] WAVEHANDS = 4'hC;
  localparam logic [3:0] MOVEJAW   = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/halloween_sequencer_decoder.sv
// 4-to-16 one-hot opcode decode plus the active / no-op / reset classification.
module opcode_decoder
  import halloween_pkg::*;
(
  input  logic [3:0]  opcode_i,
  output logic [15:0] onehot_o,
  output logic        is_active_o,
  output logic        is_nop_o,
  output logic        is_reset_o
);

  always_comb begin
    onehot_o           = '0;
    onehot_o[opcode_i] = 1'b1;
    is_reset_o         = (opcode_i == RESET);
    is_active_o        = 1'b0;
    case (opcode_i)
      FOG, GREEN, PURPLE, ORANGE, SCREAMING, CACKLING, BOO, WAVEHANDS, MOVEJAW:
        is_active_o = 1'b1;
      default: is_active_o = 1'b0;
    endcase
    // ON and the unused encodings fall in with NOOP
    is_nop_o = !is_active_o && !is_reset_o;
  end

endmodule

// File: rtl/halloween_sequencer.sv
// Steps through a packed program of 4-bit opcodes, holding each active effect for a
// fixed number of cycles; all outputs come straight from registers.
module halloween_sequencer
  import halloween_pkg::*;
#(
  parameter  int NUM_SLOTS   = 4,
  parameter  int HOLD_CYCLES = 2,
  parameter  int LOOP        = 0,
  localparam int SW          = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_valid,
  input  logic [NUM_SLOTS*4-1:0] prog_data,
  output logic                   prog_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic [SW-1:0]          stride,
  output logic [15:0]            effect,
  output logic                   effect_valid,
  output logic [SW-1:0]          slot,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                 state_q, state_d, adv_state;
  logic [NUM_SLOTS*4-1:0] program_q, program_d;
  logic                   loaded_q, loaded_d;
  logic [SW-1:0]          stride_q, stride_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic [CW-1:0]          hold_q, hold_d;
  logic [15:0]            effect_q, effect_d;
  logic                   effect_valid_q, effect_valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   prog_ready_q, prog_ready_d;
  logic [SW:0]            sum;
  logic [15:0]            onehot;
  logic                   is_active, is_nop, is_reset;

  opcode_decoder u_dec (
    .opcode_i    (program_q[4*slot_q +: 4]),
    .onehot_o    (onehot),
    .is_active_o (is_active),
    .is_nop_o    (is_nop),
    .is_reset_o  (is_reset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      program_q      <= '0;
      loaded_q       <= 1'b0;
      stride_q       <= SW'(1);
      slot_q         <= '0;
      hold_q         <= '0;
      effect_q       <= '0;
      effect_valid_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      prog_ready_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      program_q      <= program_d;
      loaded_q       <= loaded_d;
      stride_q       <= stride_d;
      slot_q         <= slot_d;
      hold_q         <= hold_d;
      effect_q       <= effect_d;
      effect_valid_q <= effect_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      prog_ready_q   <= prog_ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    program_d = program_q;
    loaded_d  = loaded_q;
    stride_d  = stride_q;
    slot_d    = slot_q;
    hold_d    = hold_q;
    // slot counter is exactly SW bits wide, so its carry marks the wrap
    sum       = {1'b0, slot_q} + {1'b0, stride_q};
    adv_state = (sum[SW] && (LOOP == 0)) ? ST_DONE : ST_FETCH;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (prog_valid) begin
            program_d = prog_data;
            loaded_d  = |prog_data;
          end
          if (start && (prog_valid ? |prog_data : loaded_q)) begin
            state_d  = ST_FETCH;
            slot_d   = '0;
            stride_d = (stride == '0) ? SW'(1) : stride;
          end
        end
        ST_FETCH: begin
          if (is_reset) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
          end else if (is_active) begin
            state_d = ST_HOLD;
            hold_d  = CW'(HOLD_CYCLES - 1);
          end else if (is_nop) begin
            state_d = adv_state;
            if (adv_state == ST_FETCH) slot_d = sum[SW-1:0];
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = adv_state;
            if (adv_state == ST_FETCH) slot_d = sum[SW-1:0];
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    effect_d       = '0;
    effect_valid_d = 1'b0;
    busy_d         = (state_d != ST_IDLE);
    prog_ready_d   = (state_d == ST_IDLE);
    done_d         = (state_d == ST_DONE);
    if (state_d == ST_HOLD) begin
      effect_valid_d = 1'b1;
      effect_d       = (state_q == ST_FETCH) ? onehot : effect_q;
    end
  end

  assign prog_ready   = prog_ready_q;
  assign effect       = effect_q;
  assign effect_valid = effect_valid_q;
  assign slot         = slot_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_halloween_sequencer.sv
// Two sequencers (run-once HOLD=2, looping HOLD=3) share stimulus and are checked each cycle
// against a trace-queue model, plus literal expectations for the directed programs.
module tb_halloween_sequencer;

  localparam int N = 4;
  localparam int HOLD_OF [2] = '{2, 3};
  localparam int LOOP_OF [2] = '{0, 1};
  localparam int QD = 64;

  typedef struct packed {
    logic        busy;
    logic        ev;
    logic        done;
    logic        clr;
    logic [15:0] eff;
    logic [1:0]  slot;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, prog_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] prog_data = '0;
  logic [1:0]  stride = '0;
  logic [1:0]  pr, ev, bz, dn;
  logic [1:0][15:0] eff;
  logic [1:0][1:0]  sl;

  int n_checks = 0, n_fail = 0;

  exp_t        mb [2][QD];
  int          hd [2], cnt [2];
  logic        m_loaded [2], gen_on [2];
  logic [15:0] m_prog [2], gen_prog [2];
  int          gen_slot [2], gen_str [2];
  logic [15:0] active_mask = 16'h3778;
  logic [15:0] t32 [14] = '{16'h0, 16'h100, 16'h100, 16'h0, 16'h20, 16'h20, 16'h0,
                             16'h10, 16'h10, 16'h0, 16'h8, 16'h8, 16'h0, 16'h0};
  logic [15:0] t33 [8]  = '{16'h0, 16'h1000, 16'h1000, 16'h0, 16'h2000, 16'h2000, 16'h0, 16'h0};

  halloween_sequencer #(.NUM_SLOTS(N), .HOLD_CYCLES(2), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(pr[0]),
    .start(start), .stop(stop), .stride(stride), .effect(eff[0]), .effect_valid(ev[0]),
    .slot(sl[0]), .busy(bz[0]), .done(dn[0]));

  halloween_sequencer #(.NUM_SLOTS(N), .HOLD_CYCLES(3), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(pr[1]),
    .start(start), .stop(stop), .stride(stride), .effect(eff[1]), .effect_valid(ev[1]),
    .slot(sl[1]), .busy(bz[1]), .done(dn[1]));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: expected per-cycle trace ----------------
  task automatic push(input int i, input exp_t e);
    mb[i][(hd[i] + cnt[i]) % QD] = e;
    cnt[i]++;
  endtask

  task automatic extend(input int i);
    exp_t e;
    logic [3:0] op;
    int s, nx;
    s  = gen_slot[i];
    op = gen_prog[i][4*s +: 4];
    e = '0; e.busy = 1'b1; e.slot = 2'(s); e.clr = (op == 4'h1);
    push(i, e);
    if (op == 4'h1) begin
      gen_on[i] = 1'b0;
      return;
    end
    if (active_mask[op]) begin
      e.ev = 1'b1; e.eff = 16'h1 << op; e.clr = 1'b0;
      for (int h = 0; h < HOLD_OF[i]; h++) push(i, e);
    end
    nx = s + gen_str[i];
    if (nx >= N && LOOP_OF[i] == 0) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      push(i, e);
      gen_on[i] = 1'b0;
    end else begin
      gen_slot[i] = nx % N;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        hd[i] = 0; cnt[i] = 0; m_loaded[i] = 1'b0; m_prog[i] = '0; gen_on[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] > 0) begin
          if (stop) begin
            cnt[i] = 0; gen_on[i] = 1'b0;
          end else begin
            if (mb[i][hd[i]].clr) m_loaded[i] = 1'b0;
            hd[i] = (hd[i] + 1) % QD;
            cnt[i]--;
          end
        end else if (!stop) begin
          logic go;
          go = prog_valid ? (prog_data != 0) : m_loaded[i];
          if (prog_valid) begin
            m_prog[i] = prog_data; m_loaded[i] = (prog_data != 0);
          end
          if (start && go) begin
            gen_on[i] = 1'b1; gen_slot[i] = 0; gen_prog[i] = m_prog[i];
            gen_str[i] = (stride == 0) ? 1 : int'(stride);
          end
        end
        while (gen_on[i] && cnt[i] < 20) extend(i);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        e = (cnt[i] > 0) ? mb[i][hd[i]] : exp_t'(0);
        check("busy", i, 32'(bz[i]), 32'(e.busy));
        check("prog_ready", i, 32'(pr[i]), 32'(!e.busy));
        check("effect_valid", i, 32'(ev[i]), 32'(e.ev));
        check("effect", i, 32'(eff[i]), 32'(e.eff));
        check("done", i, 32'(dn[i]), 32'(e.done));
        if (e.busy && !e.done) check("slot", i, 32'(sl[i]), 32'(e.slot));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] d);
    prog_valid = 1'b1; prog_data = d; tick; prog_valid = 1'b0;
  endtask

  task automatic go(input logic [1:0] s);
    start = 1'b1; stride = s; tick; start = 1'b0;
  endtask

  task automatic halt;
    stop = 1'b1; tick; stop = 1'b0;
  endtask

  task automatic lit0(input string nm, input int k, input logic [15:0] e, input int done_k);
    check({nm, "_eff"}, 0, 32'(eff[0]), 32'(e));
    check({nm, "_ev"}, 0, 32'(ev[0]), 32'(e != 0));
    check({nm, "_done"}, 0, 32'(dn[0]), 32'(k == done_k));
    check({nm, "_busy"}, 0, 32'(bz[0]), 32'(k <= done_k));
  endtask

  task automatic all_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      check({nm, "_eff"}, i, 32'(eff[i]), 0);
      check({nm, "_ev"}, i, 32'(ev[i]), 0);
      check({nm, "_busy"}, i, 32'(bz[i]), 0);
      check({nm, "_done"}, i, 32'(dn[i]), 0);
      check({nm, "_slot"}, i, 32'(sl[i]), 0);
      check({nm, "_ready"}, i, 32'(pr[i]), 0);
    end
  endtask

  initial begin
    repeat (2) tick;
    all_zero("reset");
    @(negedge clk); #1 rst = 1'b0;
    tick;
    check("ready_after_rst", 0, 32'(pr[0]), 1);
    check("ready_after_rst", 1, 32'(pr[1]), 1);

    // 0x3458, stride 1: effects 8,5,4,3 each held two cycles, then done
    load(16'h3458);
    go(2'd1);
    check("model_len_3458", 0, 32'(cnt[0]), 13);
    for (int k = 1; k <= 14; k++) begin
      lit0("p3458", k, t32[k-1], 13);
      tick;
    end
    halt;

    // 0x6D9C, stride 2: slots 0 (C) and 2 (D) only
    load(16'h6D9C);
    go(2'd2);
    for (int k = 1; k <= 8; k++) begin
      lit0("p6D9C", k, t33[k-1], 7);
      tick;
    end
    halt;

    // 0xA412: NOOP then RESET, program dropped, no done, next start ignored
    load(16'hA412);
    go(2'd1);
    check("a412_k1_busy", 0, 32'(bz[0]), 1);
    check("a412_k1_ev", 0, 32'(ev[0]), 0);
    tick;
    check("a412_k2_slot", 0, 32'(sl[0]), 1);
    check("a412_k2_ev", 0, 32'(ev[0]), 0);
    tick;
    check("a412_idle", 0, 32'(bz[0]), 0);
    check("a412_nodone", 0, 32'(dn[0]), 0);
    check("a412_idle", 1, 32'(bz[1]), 0);
    go(2'd1);
    check("a412_restart_ignored", 0, 32'(bz[0]), 0);
    check("a412_restart_ignored", 1, 32'(bz[1]), 0);

    // all-ON program is never loaded
    load(16'h0000);
    go(2'd1);
    check("zero_prog_busy", 0, 32'(bz[0]), 0);
    check("zero_prog_busy", 1, 32'(bz[1]), 0);

    // looping instance: stop during the second pass, then restart without reload
    load(16'h3458);
    go(2'd1);
    repeat (20) tick;
    check("loop_running", 1, 32'(bz[1]), 1);
    halt;
    check("stop_busy", 1, 32'(bz[1]), 0);
    check("stop_ev", 1, 32'(ev[1]), 0);
    check("stop_done", 1, 32'(dn[1]), 0);
    go(2'd1);
    check("restart_busy", 1, 32'(bz[1]), 1);
    tick;
    check("restart_ev", 1, 32'(ev[1]), 1);
    check("restart_eff", 1, 32'(eff[1]), 32'h100);
    halt;

    // asynchronous reset while holding an effect
    go(2'd1);
    tick;
    check("pre_rst_hold_ev", 0, 32'(ev[0]), 1);
    rst = 1'b1;
    #1;
    all_zero("async_rst");
    tick;
    @(negedge clk); #1 rst = 1'b0;
    tick;
    go(2'd1);
    check("post_rst_unloaded", 0, 32'(bz[0]), 0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      prog_valid = ($urandom % 4) == 0;
      case ($urandom % 8)
        0:       prog_data = 16'h0000;
        1:       prog_data = {12'($urandom), 4'h1};
        default: prog_data = 16'($urandom);
      endcase
      start  = ($urandom % 3) == 0;
      stride = 2'($urandom);
      stop   = ($urandom % 20) == 0;
      tick;
    end
    prog_valid = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
